sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised synchronous single-clock FIFO. Generalises the 8x8 FIFO in width,
//  depth and flag thresholds. Adds a registered read-valid strobe, programmable
//  almost-full/almost-empty flags, and sticky overflow/underflow error flags.
//  It sits between the BFM-driven stream producers and consumers in the test harnesses.
// PARAMETERS
//  DATA_W     8   data width in bits (>=1)
//  DEPTH      8   number of entries; power of 2, >=2
//  AF_LEVEL   6   almost_full asserted when fifo_cnt >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL   2   almost_empty asserted when fifo_cnt <= AE_LEVEL (0..DEPTH-1)
//  Derived: AW=$clog2(DEPTH) pointer width; CW=AW+1 count width
// PORTS
//  clock         in   1       clock, all logic on posedge
//  rst           in   1       reset, synchronous, active-low
//  wr            in   1       write request
//  data_in       in   DATA_W  write data, sampled when write accepted
//  rd            in   1       read request
//  clr_err       in   1       clears overflow/underflow (synchronous)
//  data_out      out  DATA_W  read data, registered
//  rd_valid      out  1       1-cycle pulse: data_out updated by accepted read
//  full          out  1       fifo_cnt==DEPTH
//  empty         out  1       fifo_cnt==0
//  almost_full   out  1       fifo_cnt>=AF_LEVEL
//  almost_empty  out  1       fifo_cnt<=AE_LEVEL
//  fifo_cnt      out  CW      current occupancy, 0..DEPTH
//  overflow      out  1       sticky: write attempted while full and not accepted
//  underflow     out  1       sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst==0 at posedge): wr_ptr=rd_ptr=0, fifo_cnt=0, data_out=0, rd_valid=0,
//    overflow=underflow=0. Memory contents are not reset. Reset overrides all inputs.
//  - full/empty/almost_* are combinational from fifo_cnt. After reset: empty=1, almost_empty=1,
//    full=0, almost_full=0.
//  - Accept rules, evaluated on pre-edge state:
//    wr_acc = wr & (!full | rd)      (write into a full FIFO is accepted only with a same-cycle read)
//    rd_acc = rd & !empty            (a read from an empty FIFO is never accepted, even with wr)
//  - wr_acc: mem[wr_ptr]<=data_in; wr_ptr<=wr_ptr+1, wrapping mod DEPTH.
//  - rd_acc: data_out<=mem[rd_ptr] (1-cycle latency); rd_ptr+1 mod DEPTH; rd_valid<=1.
//    Otherwise rd_valid<=0 and data_out holds its value.
//  - fifo_cnt: +1 if wr_acc&!rd_acc; -1 if rd_acc&!wr_acc; else unchanged. Never leaves 0..DEPTH.
//  - Simultaneous wr&rd:
//    empty -> write only, cnt 0->1, underflow set, rd_valid=0 (no write-through bypass)
//    full  -> both accepted, cnt stays DEPTH, read returns oldest entry (not data_in)
//    other -> both accepted, cnt unchanged
//  - Error flags:
//    overflow<=1 if wr & full & !rd; underflow<=1 if rd & empty.
//    clr_err clears both; a set condition in the same cycle wins over clr_err.
//  - Pointers are AW bits and wrap naturally; full/empty are never derived from pointer compare.
//  - Reset mid-stream: all data discarded; the next read after reset is refused until a write.
// TESTING
//  1 Reset: rst=0 for 2 cycles with wr=1 -> cnt=0, empty=1, almost_empty=1, data_out=0, errors=0.
//  2 Fill/drain (DEPTH=8): write 0x01..0x08 -> full=1 at cnt 8, almost_full at cnt 6; read 8 ->
//    data_out 0x01..0x08 one cycle after each rd, rd_valid high each cycle, empty=1 at end.
//  3 Over/underflow: on full, wr=1 data 0xAA -> overflow=1, cnt=8, 0xAA never read; on empty,
//    rd=1 -> underflow=1, rd_valid=0; clr_err=1 -> both cleared next cycle.
//  4 Simultaneous: wr&rd on empty with 0x55 -> cnt=1, underflow=1, then rd returns 0x55;
//    wr&rd on full -> cnt stays 8, data_out=oldest entry.
//  5 Wrap: 20 cycles of interleaved single writes and reads at cnt 3 -> FIFO order preserved
//    across pointer wrap, cnt constant at 3.
//  6 Params: DATA_W=32, DEPTH=16, AF_LEVEL=16, AE_LEVEL=0 -> fifo_cnt 5 bits,
//    almost_full==full, almost_empty==empty throughout a fill/drain.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
// The master side drives requests and write data; the slave side (the FIFO) returns data and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, data_in, rd, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           fifo_cnt, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           fifo_cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost flags and sticky overflow/underflow errors.
// Latency: read data registered, valid one cycle after an accepted read.
// Backpressure: writes to a full FIFO are refused unless paired with a read; empty reads refused.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input logic              clock,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;
  logic              ovf_q;
  logic              udf_q;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Status comes from the occupancy counter alone, never from pointer compare.
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign wr_acc = bus.wr & (~full | bus.rd);
  assign rd_acc = bus.rd & ~empty;

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= CW'(AF_LEVEL));
  assign bus.almost_empty = ~(cnt > CW'(AE_LEVEL));
  assign bus.fifo_cnt     = cnt;
  assign bus.data_out     = data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  always_ff @(posedge clock) begin
    if (rst && wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        data_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd_acc;

      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      // A fresh error in the same cycle as clr_err must stay visible.
      if (bus.wr & full & ~bus.rd) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
      if (bus.rd & empty) begin
        udf_q <= 1'b1;
      end else if (bus.clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: default 8x8 instance plus a 32x16 instance with extreme thresholds.
// A queue holds accepted write data; reads pop it to form the expected data_out.
module tb_sync_fifo_param;
  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  sync_fifo_param_if #(.DATA_W(8),  .DEPTH(8))  bus  ();
  sync_fifo_param_if #(.DATA_W(32), .DEPTH(16)) bus2 ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(16), .AF_LEVEL(16), .AE_LEVEL(0)) dut2 (
    .clock (clock),
    .rst   (rst),
    .bus   (bus2)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  sb [$];
  logic [31:0] sb2 [$];
  logic [7:0]  exp_dout;
  logic        exp_vld;
  logic        exp_ovf;
  logic        exp_udf;

  task automatic model_reset();
    sb.delete();
    sb2.delete();
    exp_dout = 8'h00;
    exp_vld  = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  // Drives one cycle on the 8-bit instance and advances the reference model.
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    int   n;
    logic wacc;
    logic racc;
    n    = sb.size();
    racc = r && (n > 0);
    wacc = w && ((n < 8) || r);
    exp_vld = racc;
    if (racc) exp_dout = sb.pop_front();
    if (wacc) sb.push_back(d);
    if (w && (n == 8) && !r) exp_ovf = 1'b1;
    else if (c)              exp_ovf = 1'b0;
    if (r && (n == 0))       exp_udf = 1'b1;
    else if (c)              exp_udf = 1'b0;
    bus.wr = w; bus.data_in = d; bus.rd = r; bus.clr_err = c;
    @(posedge clock);
    #1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wr = 1'b1;
    bus.data_in = 8'hEE;
    repeat (2) @(posedge clock);
    #1;
    bus.wr = 1'b0;
    model_reset();
    checks++; if (bus.fifo_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt actual=%0d required=0", bus.fifo_cnt); end
    checks++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin
      failures++; $display("FAIL reset_flags actual=%b required=1100", {bus.empty, bus.almost_empty, bus.full, bus.almost_full}); end
    checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data actual=%h required=00", bus.data_out); end
    checks++; if ({bus.rd_valid, bus.overflow, bus.underflow} !== 3'b000) begin
      failures++; $display("FAIL reset_vld_err actual=%b required=000", {bus.rd_valid, bus.overflow, bus.underflow}); end
    checks++; if ({bus2.empty, bus2.almost_empty, bus2.fifo_cnt} !== {2'b11, 5'd0}) begin
      failures++; $display("FAIL reset_p2 actual=%b/%b/%0d required=1/1/0", bus2.empty, bus2.almost_empty, bus2.fifo_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    int n;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      n = sb.size();
      checks++; if (bus.fifo_cnt !== 4'(n)) begin failures++; $display("FAIL fill_cnt actual=%0d required=%0d", bus.fifo_cnt, n); end
      checks++; if ({bus.full, bus.almost_full, bus.almost_empty, bus.empty} !== {n == 8, n >= 6, n <= 2, n == 0}) begin
        failures++; $display("FAIL fill_flags cnt=%0d actual=%b required=%b", n,
          {bus.full, bus.almost_full, bus.almost_empty, bus.empty}, {n == 8, n >= 6, n <= 2, n == 0}); end
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n = sb.size();
      checks++; if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_dout) begin
        failures++; $display("FAIL drain_data actual=%b/%h required=1/%h", bus.rd_valid, bus.data_out, exp_dout); end
      checks++; if ({bus.full, bus.almost_full, bus.almost_empty, bus.empty} !== {n == 8, n >= 6, n <= 2, n == 0}) begin
        failures++; $display("FAIL drain_flags cnt=%0d actual=%b", n, {bus.full, bus.almost_full, bus.almost_empty, bus.empty}); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 8'h08) begin
      failures++; $display("FAIL idle_hold actual=%b/%h required=0/08", bus.rd_valid, bus.data_out); end
  endtask

  task automatic test_over_underflow();
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.fifo_cnt !== 4'd8) begin
      failures++; $display("FAIL ovf_set actual=%b/%0d required=1/8", bus.overflow, bus.fifo_cnt); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.data_out !== exp_dout) begin failures++; $display("FAIL ovf_drain actual=%h required=%h", bus.data_out, exp_dout); end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.fifo_cnt !== 4'd0) begin
      failures++; $display("FAIL udf_set actual=%b/%b/%0d required=1/0/0", bus.underflow, bus.rd_valid, bus.fifo_cnt); end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if ({bus.overflow, bus.underflow} !== {exp_ovf, exp_udf}) begin
      failures++; $display("FAIL set_beats_clr actual=%b required=%b", {bus.overflow, bus.underflow}, {exp_ovf, exp_udf}); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin
      failures++; $display("FAIL clr_err actual=%b required=00", {bus.overflow, bus.underflow}); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (bus.fifo_cnt !== 4'd1 || bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin
      failures++; $display("FAIL sim_empty actual=%0d/%b/%b required=1/1/0", bus.fifo_cnt, bus.underflow, bus.rd_valid); end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (bus.data_out !== 8'h55 || bus.rd_valid !== 1'b1) begin
      failures++; $display("FAIL sim_empty_read actual=%h/%b required=55/1", bus.data_out, bus.rd_valid); end
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    checks++; if (bus.fifo_cnt !== 4'd8 || bus.data_out !== 8'h20 || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL sim_full actual=%0d/%h/%b required=8/20/0", bus.fifo_cnt, bus.data_out, bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.data_out !== exp_dout) begin failures++; $display("FAIL sim_drain actual=%h required=%h", bus.data_out, exp_dout); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      checks++; if (bus.fifo_cnt !== 4'd3 || bus.rd_valid !== 1'b1 || bus.data_out !== exp_dout) begin
        failures++; $display("FAIL wrap actual=%0d/%b/%h required=3/1/%h", bus.fifo_cnt, bus.rd_valid, bus.data_out, exp_dout); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.data_out !== exp_dout) begin failures++; $display("FAIL wrap_drain actual=%h required=%h", bus.data_out, exp_dout); end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b1;
    model_reset();
    checks++; if (bus.fifo_cnt !== 4'd0 || bus.data_out !== 8'h00 || bus.empty !== 1'b1) begin
      failures++; $display("FAIL mid_reset actual=%0d/%h/%b required=0/00/1", bus.fifo_cnt, bus.data_out, bus.empty); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.rd_valid !== 1'b0 || bus.underflow !== 1'b1) begin
      failures++; $display("FAIL mid_reset_read actual=%b/%b required=0/1", bus.rd_valid, bus.underflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_params();
    int          n;
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      sb2.push_back(d);
      bus2.wr = 1'b1; bus2.data_in = d;
      @(posedge clock);
      #1;
      bus2.wr = 1'b0;
      n = sb2.size();
      checks++; if (bus2.fifo_cnt !== 5'(n)) begin failures++; $display("FAIL p2_cnt actual=%0d required=%0d", bus2.fifo_cnt, n); end
      checks++; if ({bus2.almost_full, bus2.full, bus2.almost_empty, bus2.empty} !== {n == 16, n == 16, 2'b00}) begin
        failures++; $display("FAIL p2_fill_flags cnt=%0d actual=%b", n, {bus2.almost_full, bus2.full, bus2.almost_empty, bus2.empty}); end
    end
    for (int i = 0; i < 16; i++) begin
      e = sb2.pop_front();
      bus2.rd = 1'b1;
      @(posedge clock);
      #1;
      bus2.rd = 1'b0;
      n = sb2.size();
      checks++; if (bus2.data_out !== e || bus2.rd_valid !== 1'b1) begin
        failures++; $display("FAIL p2_data actual=%h/%b required=%h/1", bus2.data_out, bus2.rd_valid, e); end
      checks++; if ({bus2.almost_full, bus2.full, bus2.almost_empty, bus2.empty} !== {2'b00, n == 0, n == 0}) begin
        failures++; $display("FAIL p2_drain_flags cnt=%0d actual=%b", n, {bus2.almost_full, bus2.full, bus2.almost_empty, bus2.empty}); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0; bus.data_in = 8'h00;
    bus2.wr = 1'b0; bus2.rd = 1'b0; bus2.clr_err = 1'b0; bus2.data_in = 32'h0;
    model_reset();
    @(posedge clock);
    #1;
    test_reset();
    test_fill_drain();
    test_over_underflow();
    test_simultaneous();
    test_wrap();
    test_reset_midstream();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
